// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and alignment rule for the unified memory port.
package mem_pkg;

    // Load type encodings carried on dm_rctrl
    localparam logic [2:0] LB  = 3'd1;
    localparam logic [2:0] LH  = 3'd2;
    localparam logic [2:0] LW  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    // Store type encodings carried on dm_wctrl; any nonzero value is a write
    localparam logic [1:0] SB  = 2'd1;
    localparam logic [1:0] SH  = 2'd2;
    localparam logic [1:0] SW  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // True when the access cannot be served as a single aligned word-port access.
    // A nonzero store type takes precedence over the load type.
    function automatic logic is_misaligned(input logic       is_fetch,
                                           input logic [2:0] rctrl,
                                           input logic [1:0] wctrl,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (is_fetch) begin
            mis = |addr_lo;
        end else if (wctrl != 2'd0) begin
            case (wctrl)
                SH:      mis = addr_lo[0];
                SW:      mis = |addr_lo;
                default: mis = 1'b0;
            endcase
        end else begin
            case (rctrl)
                LH, LHU: mis = addr_lo[0];
                LB, LBU: mis = 1'b0;
                default: mis = |addr_lo;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store byte enables and lane replication, load lane
// extraction with sign/zero extension. Purely combinational.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  rctrl,
    input  logic [1:0]  wctrl,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: narrow stores are replicated so every lane carries the data
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        case (wctrl)
            SB: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane and extend it to a full word
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (rctrl)
            LB:      rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            LBU:     rdata_ext = {24'd0, byte_sel};
            LH:      rdata_ext = {{16{half_sel[15]}}, half_sel};
            LHU:     rdata_ext = {16'd0, half_sel};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// the load/store unit, with an IDLE/ACCESS/RESP sequencer and access timeout.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    output logic              if_err,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [2:0]        dm_rctrl,
    input  logic [1:0]        dm_wctrl,
    output logic [31:0]       dm_rdata,
    output logic              dm_ack,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic             last_dm;
    logic             gnt_dm;
    logic [1:0]       addr_lo_q;
    logic [2:0]       rctrl_q;
    logic [1:0]       wctrl_q;
    logic [CNT_W-1:0] cnt;

    logic              pick_dm;
    logic [ADDR_W-1:0] cand_addr;
    logic [2:0]        cand_rctrl;
    logic [1:0]        cand_wctrl;
    logic              cand_mis;
    logic [1:0]        fmt_addr_lo;
    logic [2:0]        fmt_rctrl;
    logic [1:0]        fmt_wctrl;
    logic [3:0]        fmt_be;
    logic [31:0]       fmt_wdata;
    logic [31:0]       fmt_rdata;

    // Candidate grant from live requests; the formatter sees it while IDLE and
    // the registered request afterwards, so one formatter serves both phases
    always_comb begin
        pick_dm    = dm_req && (!if_req || !last_dm);
        cand_addr  = pick_dm ? dm_addr : if_addr;
        cand_wctrl = pick_dm ? dm_wctrl : 2'd0;
        cand_rctrl = LW;
        if (pick_dm && dm_wctrl == 2'd0) begin
            case (dm_rctrl)
                LB, LH, LBU, LHU: cand_rctrl = dm_rctrl;
                default:          cand_rctrl = LW;
            endcase
        end
        cand_mis = is_misaligned(!pick_dm, cand_rctrl, cand_wctrl, cand_addr[1:0]);
        if (state == IDLE) begin
            fmt_addr_lo = cand_addr[1:0];
            fmt_rctrl   = cand_rctrl;
            fmt_wctrl   = cand_wctrl;
        end else begin
            fmt_addr_lo = addr_lo_q;
            fmt_rctrl   = rctrl_q;
            fmt_wctrl   = wctrl_q;
        end
    end

    mem_lane_fmt u_fmt (
        .addr_lo    (fmt_addr_lo),
        .rctrl      (fmt_rctrl),
        .wctrl      (fmt_wctrl),
        .wdata      (dm_wdata),
        .rdata      (mem_rdata),
        .be         (fmt_be),
        .wdata_lane (fmt_wdata),
        .rdata_ext  (fmt_rdata)
    );

    assign busy = (state != IDLE);

    // Access sequencer: grant, drive the port until ready or timeout, then ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_dm   <= 1'b0;
            gnt_dm    <= 1'b0;
            addr_lo_q <= 2'd0;
            rctrl_q   <= 3'd0;
            wctrl_q   <= 2'd0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= 32'd0;
            dm_ack    <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= 32'd0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        gnt_dm    <= pick_dm;
                        last_dm   <= pick_dm;
                        addr_lo_q <= cand_addr[1:0];
                        rctrl_q   <= cand_rctrl;
                        wctrl_q   <= cand_wctrl;
                        cnt       <= '0;
                        if (cand_mis) begin
                            state <= RESP;
                            if (pick_dm) begin
                                dm_ack <= 1'b1;
                                dm_err <= 1'b1;
                            end else begin
                                if_ack <= 1'b1;
                                if_err <= 1'b1;
                            end
                        end else begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= (cand_wctrl != 2'd0);
                            mem_addr  <= {cand_addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= fmt_be;
                            mem_wdata <= fmt_wdata;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (gnt_dm) begin
                            dm_ack <= 1'b1;
                            dm_err <= 1'b0;
                            if (wctrl_q == 2'd0) dm_rdata <= fmt_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_err   <= 1'b0;
                            if_rdata <= fmt_rdata;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (gnt_dm) begin
                            dm_ack <= 1'b1;
                            dm_err <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                            if_err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    if_err <= 1'b0;
                    dm_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed and random transactions
// compared against a byte-size/offset model of the memory port behaviour.
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack, if_err;
    logic        dm_req = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [2:0]  dm_rctrl = '0;
    logic [1:0]  dm_wctrl = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack, dm_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit tb_last_dm = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rctrl(dm_rctrl),
        .dm_wctrl(dm_wctrl), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Access size in bytes, write flag and signedness derived from the request
    task automatic decode(input bit dm, input logic [2:0] rc, input logic [1:0] wc,
                          output int sz, output bit wr, output bit sgn);
        sz = 4; wr = 1'b0; sgn = 1'b0;
        if (dm && wc != 2'd0) begin
            wr = 1'b1;
            sz = (wc == 2'd1) ? 1 : (wc == 2'd2) ? 2 : 4;
        end else if (dm) begin
            case (rc)
                3'd1: begin sz = 1; sgn = 1'b1; end
                3'd2: begin sz = 2; sgn = 1'b1; end
                3'd4: sz = 1;
                3'd5: sz = 2;
                default: sz = 4;
            endcase
        end
    endtask

    function automatic logic [31:0] load_model(input logic [31:0] word, input int off,
                                               input int sz, input bit sgn);
        logic [31:0] mask, v;
        if (sz == 4) return word;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (word >> (8 * off)) & mask;
        if (sgn && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic single(input bit dm, input logic [31:0] addr, input logic [2:0] rc,
                          input logic [1:0] wc, input logic [31:0] wd, input int waits,
                          input bit use_fix, input logic [31:0] fix, input string tag);
        int sz, off, k, exp_cyc;
        bit wr, sgn, mis, exp_err;
        logic [31:0] exp_be, exp_wd, rd_at_ready;
        decode(dm, rc, wc, sz, wr, sgn);
        off = int'(addr[1:0]);
        mis = (off % sz) != 0;
        exp_be = wr ? (((32'd1 << sz) - 32'd1) << off) : 32'hF;
        exp_wd = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                 (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        rd_at_ready = '0;
        if (dm) begin
            dm_req = 1'b1; dm_addr = addr; dm_rctrl = rc; dm_wctrl = wc; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        step();
        tb_last_dm = dm;
        if (mis) begin
            chk({tag, "_noreq"}, mem_req, 0);
            chk({tag, "_ack"}, dm ? dm_ack : if_ack, 1);
            chk({tag, "_err"}, dm ? dm_err : if_err, 1);
            chk({tag, "_other"}, dm ? if_ack : dm_ack, 0);
        end else begin
            chk({tag, "_req"}, mem_req, 1);
            chk({tag, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
            chk({tag, "_we"}, mem_we, wr);
            chk({tag, "_be"}, mem_be, exp_be);
            if (wr) chk({tag, "_wdata"}, mem_wdata, exp_wd);
            chk({tag, "_busy"}, busy, 1);
            exp_cyc = (waits < TO) ? waits + 1 : TO;
            exp_err = (waits >= TO);
            k = 1;
            while (mem_req === 1'b1 && k <= TO + 2) begin
                chk({tag, "_noack"}, {if_ack, dm_ack}, 0);
                chk({tag, "_hold"}, mem_addr, addr & 32'hFFFF_FFFC);
                mem_ready = (k - 1 >= waits);
                mem_rdata = use_fix ? fix : $urandom;
                if (mem_ready) rd_at_ready = mem_rdata;
                step();
                if (mem_req === 1'b1) k++;
            end
            mem_ready = 1'b0;
            chk({tag, "_cycles"}, k, exp_cyc);
            chk({tag, "_ack"}, dm ? dm_ack : if_ack, 1);
            chk({tag, "_err"}, dm ? dm_err : if_err, exp_err);
            chk({tag, "_other"}, dm ? if_ack : dm_ack, 0);
            if (!exp_err && !wr)
                chk({tag, "_rdata"}, dm ? dm_rdata : if_rdata, load_model(rd_at_ready, off, sz, sgn));
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        chk({tag, "_ackdrop"}, {if_ack, dm_ack}, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    // Both sides request together; the side opposite the last grant wins
    task automatic conflict(input logic [31:0] da, input logic [31:0] ia, input string tag);
        bit first_dm;
        int n;
        logic [31:0] r;
        first_dm = !tb_last_dm;
        r = $urandom;
        if_req = 1'b1; if_addr = ia;
        dm_req = 1'b1; dm_addr = da; dm_rctrl = 3'd3; dm_wctrl = 2'd0;
        mem_ready = 1'b1; mem_rdata = r;
        step();
        chk({tag, "_win_addr"}, mem_addr, first_dm ? da : ia);
        n = 0;
        while (!(if_ack || dm_ack) && n < 10) begin step(); n++; end
        chk({tag, "_first_dm"}, dm_ack, first_dm);
        chk({tag, "_first_if"}, if_ack, !first_dm);
        chk({tag, "_first_rd"}, first_dm ? dm_rdata : if_rdata, r);
        if (first_dm) dm_req = 1'b0; else if_req = 1'b0;
        step();
        step();
        chk({tag, "_lose_addr"}, mem_addr, first_dm ? ia : da);
        chk({tag, "_lose_req"}, mem_req, 1);
        n = 0;
        while (!(if_ack || dm_ack) && n < 10) begin step(); n++; end
        chk({tag, "_second_dm"}, dm_ack, !first_dm);
        chk({tag, "_second_if"}, if_ack, first_dm);
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        step();
        tb_last_dm = !first_dm;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_acks", {if_ack, dm_ack, if_err, dm_err}, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tb_last_dm = 1'b0;
        step();

        // directed
        single(0, 32'h100, 3'd0, 2'd0, 32'd0, 0, 0, 32'd0, "if_basic");
        conflict(32'h200, 32'h300, "conf1");
        conflict(32'h204, 32'h304, "conf2");
        single(1, 32'h203, 3'd0, 2'd1, 32'h0000_00A5, 0, 0, 32'd0, "sb");
        single(1, 32'h203, 3'd1, 2'd0, 32'd0, 0, 1, 32'h8012_3456, "lb");
        single(1, 32'h203, 3'd4, 2'd0, 32'd0, 1, 1, 32'h8012_3456, "lbu");
        single(1, 32'h206, 3'd0, 2'd2, 32'h1234_BEEF, 2, 0, 32'd0, "sh");
        single(1, 32'h206, 3'd2, 2'd0, 32'd0, 0, 1, 32'h8001_0000, "lh");
        single(1, 32'h206, 3'd5, 2'd0, 32'd0, 0, 1, 32'h8001_0000, "lhu");
        single(1, 32'h202, 3'd3, 2'd0, 32'd0, 0, 0, 32'd0, "lw_mis");
        single(1, 32'h201, 3'd0, 2'd2, 32'd0, 0, 0, 32'd0, "sh_mis");
        single(1, 32'h203, 3'd5, 2'd0, 32'd0, 0, 0, 32'd0, "lhu_mis");
        single(0, 32'h102, 3'd0, 2'd0, 32'd0, 0, 0, 32'd0, "if_mis");
        single(1, 32'h20C, 3'd0, 2'd0, 32'd0, 0, 1, 32'hCAFE_F00D, "none_is_lw");
        single(1, 32'h208, 3'd1, 2'd3, 32'hDEAD_BEEF, 0, 0, 32'd0, "write_wins");
        single(0, 32'h300, 3'd0, 2'd0, 32'd0, 1000, 0, 32'd0, "if_timeout");
        single(1, 32'h310, 3'd0, 2'd3, 32'h5, 1000, 0, 32'd0, "dm_timeout");
        single(1, 32'h314, 3'd3, 2'd0, 32'd0, TO - 1, 0, 32'd0, "last_cycle_ready");

        // random traffic
        for (int i = 0; i < 40; i++) begin
            logic [2:0] rc;
            logic [1:0] wc;
            rc = 3'($urandom_range(0, 5));
            wc = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if (i % 8 == 7)
                conflict($urandom & 32'h0000_FFFC, $urandom & 32'h0000_FFFC, $sformatf("rconf%0d", i));
            else
                single(1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFF, rc, wc, $urandom,
                       $urandom_range(0, 3), 0, 32'd0, $sformatf("rnd%0d", i));
        end

        // reset in the middle of an access
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b0;
        step();
        chk("mid_req", mem_req, 1);
        step();
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_be", mem_be, 0);
        chk("arst_busy", busy, 0);
        chk("arst_acks", {if_ack, dm_ack, if_err, dm_err}, 0);
        chk("arst_rdata", if_rdata | dm_rdata, 0);
        if_req = 1'b0;
        mem_ready = 1'b1;
        step();
        chk("arst_noack", {if_ack, dm_ack}, 0);
        step();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        tb_last_dm = 1'b0;
        step();
        single(0, 32'h80, 3'd0, 2'd0, 32'd0, 0, 0, 32'd0, "post_rst");
        conflict(32'h400, 32'h500, "post_rst_conf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
